// File: rtl/conv_pkg.sv
// Shared widths, mode encoding and tap-weighting helper for the 3x3 Sobel filter.
package conv_pkg;

    localparam int unsigned PIX_W  = 12;
    localparam int unsigned SUM_W  = 14;
    localparam int unsigned GRAD_W = 15;

    localparam logic [PIX_W-1:0] PIX_MAX = 12'd4095;

    typedef enum logic [1:0] {
        CONV_PASS,
        CONV_GX,
        CONV_GY,
        CONV_MAG
    } conv_mode_e;

    // a + 2m + b, the 1-2-1 smoothing used on every Sobel edge row/column
    function automatic logic [SUM_W-1:0] tap_sum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] m,
        input logic [PIX_W-1:0] b
    );
        return SUM_W'(a) + (SUM_W'(m) << 1) + SUM_W'(b);
    endfunction

endpackage

// File: rtl/conv_abs_clamp.sv
// Stage-3 combinational reduction: gradient abs, mode select, right shift and
// saturation to the 12-bit pixel range. Passthrough mode skips shift and clamp.
module conv_abs_clamp
    import conv_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic signed [GRAD_W-1:0] gx,
    input  logic signed [GRAD_W-1:0] gy,
    input  logic        [PIX_W-1:0]  centre,
    input  logic        [1:0]        mode,
    output logic        [PIX_W-1:0]  pix
);

    logic [SUM_W-1:0]  abs_x;
    logic [SUM_W-1:0]  abs_y;
    logic [GRAD_W-1:0] sel;
    logic [GRAD_W-1:0] shifted;

    always_comb begin
        abs_x = gx[GRAD_W-1] ? SUM_W'(-gx) : SUM_W'(gx);
        abs_y = gy[GRAD_W-1] ? SUM_W'(-gy) : SUM_W'(gy);

        sel = '0;
        unique case (conv_mode_e'(mode))
            CONV_GX:  sel = {1'b0, abs_x};
            CONV_GY:  sel = {1'b0, abs_y};
            CONV_MAG: sel = GRAD_W'(abs_x) + GRAD_W'(abs_y);
            default:  sel = '0;
        endcase

        shifted = sel >> OUT_SHIFT;

        if (conv_mode_e'(mode) == CONV_PASS)
            pix = centre;
        else if (shifted > GRAD_W'(PIX_MAX))
            pix = PIX_MAX;
        else
            pix = shifted[PIX_W-1:0];
    end

endmodule

// File: rtl/conv3x3_sobel_filter.sv
// 3-stage 3x3 Sobel / passthrough filter with window-centre coordinate tracking.
// Optional binarisation of the output pixel when CONV_THRESH_EN is defined.
module conv3x3_sobel_filter
    import conv_pkg::*;
#(
    parameter int unsigned      IMG_W     = 640,
    parameter int unsigned      IMG_H     = 480,
    parameter int unsigned      OUT_SHIFT = 0,
    parameter logic [PIX_W-1:0] THRESH    = 12'd1024
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    input  logic [PIX_W-1:0] w00,
    input  logic [PIX_W-1:0] w01,
    input  logic [PIX_W-1:0] w02,
    input  logic [PIX_W-1:0] w10,
    input  logic [PIX_W-1:0] w11,
    input  logic [PIX_W-1:0] w12,
    input  logic [PIX_W-1:0] w20,
    input  logic [PIX_W-1:0] w21,
    input  logic [PIX_W-1:0] w22,
    input  logic [1:0]       iMode,
    output logic             oDVAL,
    output logic [PIX_W-1:0] oPIXEL,
    output logic [9:0]       oX,
    output logic [9:0]       oY,
    output logic             oEOF
);

    localparam logic [9:0] X_LAST = 10'(IMG_W - 2);
    localparam logic [9:0] Y_LAST = 10'(IMG_H - 2);

    logic             s1_v;
    conv_mode_e       s1_mode;
    logic [PIX_W-1:0] s1_c;
    logic [SUM_W-1:0] s1_l, s1_r, s1_t, s1_b;

    logic                     s2_v;
    conv_mode_e               s2_mode;
    logic        [PIX_W-1:0]  s2_c;
    logic signed [GRAD_W-1:0] s2_gx, s2_gy;

    logic [9:0]       x_cnt, y_cnt;
    logic             at_last;
    logic [PIX_W-1:0] clamp_pix;
    logic [PIX_W-1:0] pix_out;

    conv_abs_clamp #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_abs_clamp (
        .gx     (s2_gx),
        .gy     (s2_gy),
        .centre (s2_c),
        .mode   (s2_mode),
        .pix    (clamp_pix)
    );

`ifdef CONV_THRESH_EN
    assign pix_out = (clamp_pix >= THRESH) ? PIX_MAX : '0;
`else
    logic unused_thresh;
    assign pix_out       = clamp_pix;
    assign unused_thresh = ^THRESH;
`endif

    assign at_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_v    <= 1'b0;
            s1_mode <= CONV_PASS;
            s1_c    <= '0;
            s1_l    <= '0;
            s1_r    <= '0;
            s1_t    <= '0;
            s1_b    <= '0;
            s2_v    <= 1'b0;
            s2_mode <= CONV_PASS;
            s2_c    <= '0;
            s2_gx   <= '0;
            s2_gy   <= '0;
            oDVAL   <= 1'b0;
            oPIXEL  <= '0;
            oEOF    <= 1'b0;
        end else begin
            s1_v    <= iValid;
            s1_mode <= conv_mode_e'(iMode);
            s1_c    <= w11;
            s1_l    <= tap_sum(w00, w10, w20);
            s1_r    <= tap_sum(w02, w12, w22);
            s1_t    <= tap_sum(w00, w01, w02);
            s1_b    <= tap_sum(w20, w21, w22);

            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_c    <= s1_c;
            s2_gx   <= $signed({1'b0, s1_r}) - $signed({1'b0, s1_l});
            s2_gy   <= $signed({1'b0, s1_b}) - $signed({1'b0, s1_t});

            oDVAL   <= s2_v;
            oPIXEL  <= pix_out;
            oEOF    <= s2_v && at_last;
        end
    end

    // x_cnt/y_cnt hold the coordinate the next emitted pixel will carry
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_cnt <= 10'd1;
            y_cnt <= 10'd1;
            oX    <= 10'd1;
            oY    <= 10'd1;
        end else if (s2_v) begin
            oX <= x_cnt;
            oY <= y_cnt;
            if (x_cnt == X_LAST) begin
                x_cnt <= 10'd1;
                y_cnt <= (y_cnt == Y_LAST) ? 10'd1 : y_cnt + 10'd1;
            end else begin
                x_cnt <= x_cnt + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_sobel_filter.sv
// Randomised + directed bench for conv3x3_sobel_filter against a kernel-level model.
// Honours CONV_THRESH_EN in the reference model when the macro is defined.
module tb_conv3x3_sobel_filter;

    localparam int W  = 8;
    localparam int H  = 5;
    localparam int TH = 1024;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iValid = 1'b0;
    logic [1:0]  iMode = 2'd0;
    logic [11:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;

    logic        oDVAL, oEOF;
    logic [11:0] oPIXEL;
    logic [9:0]  oX, oY;
    logic        sh_dval, sh_eof;
    logic [11:0] sh_pixel;
    logic [9:0]  sh_x, sh_y;

    conv3x3_sobel_filter #(
        .IMG_W     (W),
        .IMG_H     (H),
        .OUT_SHIFT (0),
        .THRESH    (12'(TH))
    ) dut (
        .iCLK (iCLK), .iRST (iRST), .iValid (iValid),
        .w00 (w00), .w01 (w01), .w02 (w02),
        .w10 (w10), .w11 (w11), .w12 (w12),
        .w20 (w20), .w21 (w21), .w22 (w22),
        .iMode (iMode),
        .oDVAL (oDVAL), .oPIXEL (oPIXEL), .oX (oX), .oY (oY), .oEOF (oEOF)
    );

    conv3x3_sobel_filter #(
        .IMG_W     (W),
        .IMG_H     (H),
        .OUT_SHIFT (4),
        .THRESH    (12'(TH))
    ) dut_sh (
        .iCLK (iCLK), .iRST (iRST), .iValid (iValid),
        .w00 (w00), .w01 (w01), .w02 (w02),
        .w10 (w10), .w11 (w11), .w12 (w12),
        .w20 (w20), .w21 (w21), .w22 (w22),
        .iMode (iMode),
        .oDVAL (sh_dval), .oPIXEL (sh_pixel), .oX (sh_x), .oY (sh_y), .oEOF (sh_eof)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        bit v;
        int pix0;
        int pix4;
        int x;
        int y;
        bit eof;
    } exp_t;

    exp_t q[$];
    int   tw[3][3];
    int   checks = 0;
    int   failures = 0;
    int   mx = 1;
    int   my = 1;
    int   eof_seen = 0;

    always @(negedge iCLK) if (oEOF === 1'b1) eof_seen++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Sobel response straight from the kernel definition on the 3x3 window
    function automatic int filt(input int mode, input int sh);
        int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        int gx = 0;
        int gy = 0;
        int v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                gx += kx[r][c] * tw[r][c];
                gy += kx[c][r] * tw[r][c];
            end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        if (mode == 0) v = tw[1][1];
        else begin
            v = (mode == 1) ? gx : (mode == 2) ? gy : gx + gy;
            v = v >> sh;
            if (v > 4095) v = 4095;
        end
`ifdef CONV_THRESH_EN
        v = (v >= TH) ? 4095 : 0;
`endif
        return v;
    endfunction

    task automatic push_exp(input bit v, input int mode);
        exp_t e;
        e.v    = v;
        e.pix0 = filt(mode, 0);
        e.pix4 = filt(mode, 4);
        e.x    = mx;
        e.y    = my;
        e.eof  = v && (mx == W - 2) && (my == H - 2);
        if (v) begin
            if (mx == W - 2) begin
                mx = 1;
                my = (my == H - 2) ? 1 : my + 1;
            end else mx++;
        end
        q.push_back(e);
    endtask

    task automatic check_exp(input exp_t e);
        check_val("dval", oDVAL, e.v);
        check_val("dval_sh", sh_dval, e.v);
        check_val("eof", oEOF, e.eof);
        check_val("eof_sh", sh_eof, e.eof);
        if (e.v) begin
            check_val("pixel", oPIXEL, e.pix0);
            check_val("pixel_sh", sh_pixel, e.pix4);
            check_val("x", oX, e.x);
            check_val("y", oY, e.y);
            check_val("x_sh", sh_x, e.x);
            check_val("y_sh", sh_y, e.y);
        end
    endtask

    task automatic step(input bit v, input int mode);
        exp_t e;
        @(negedge iCLK);
        e = q.pop_front();
        check_exp(e);
        iValid = v;
        iMode  = 2'(mode);
        w00 = 12'(tw[0][0]); w01 = 12'(tw[0][1]); w02 = 12'(tw[0][2]);
        w10 = 12'(tw[1][0]); w11 = 12'(tw[1][1]); w12 = 12'(tw[1][2]);
        w20 = 12'(tw[2][0]); w21 = 12'(tw[2][1]); w22 = 12'(tw[2][2]);
        push_exp(v, mode);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        @(negedge iCLK);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_exp(e);
        end
        iRST   = 1'b1;
        iValid = 1'b0;
        repeat (n) begin
            @(negedge iCLK);
            check_val("rst_dval", oDVAL, 0);
            check_val("rst_dval_sh", sh_dval, 0);
            check_val("rst_eof", oEOF, 0);
            check_val("rst_pixel", oPIXEL, 0);
            check_val("rst_x", oX, 1);
            check_val("rst_y", oY, 1);
        end
        iRST = 1'b0;
        q.delete();
        mx = 1;
        my = 1;
        for (int i = 0; i < 3; i++) begin
            e = '{v: 1'b0, pix0: 0, pix4: 0, x: 1, y: 1, eof: 1'b0};
            q.push_back(e);
        end
    endtask

    task automatic fill(input int val);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) tw[r][c] = val;
    endtask

    task automatic fill_col(input int c, input int val);
        for (int r = 0; r < 3; r++) tw[r][c] = val;
    endtask

    task automatic randomise_taps();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) tw[r][c] = int'($urandom_range(0, 4095));
    endtask

    initial begin
        int got;
        int eof_base;
        fill(0);
        w00 = '0; w01 = '0; w02 = '0; w10 = '0; w11 = '0;
        w12 = '0; w20 = '0; w21 = '0; w22 = '0;

        do_reset(3);

        fill(2000);
        for (int m = 0; m < 4; m++) step(1'b1, m);
        repeat (3) step(1'b0, 0);

        fill(0);
        fill_col(2, 100);
        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 3);
        fill(0);
        fill_col(0, 100);
        step(1'b1, 1);
        fill(0);
        fill_col(2, 300);
        step(1'b1, 1);
        fill(0);
        fill_col(2, 4095);
        step(1'b1, 3);
        step(1'b1, 1);
        step(1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            randomise_taps();
            step(i % 3 != 2, (i % 2 != 0) ? 2 : 1);
        end

        for (int i = 0; i < 300; i++) begin
            randomise_taps();
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
        end
        repeat (4) step(1'b0, 0);

        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            randomise_taps();
            step(1'b1, 3);
        end
        do_reset(3);
        repeat (3) step(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            randomise_taps();
            step(1'b1, 1);
        end
        repeat (4) step(1'b0, 0);

        do_reset(2);
        eof_base = eof_seen;
        got = 0;
        while (got < 2 * (W - 2) * (H - 2)) begin
            bit v;
            v = $urandom_range(0, 3) != 0;
            randomise_taps();
            step(v, int'($urandom_range(0, 3)));
            if (v) got++;
        end
        repeat (4) step(1'b0, 0);
        check_val("eof_count", eof_seen - eof_base, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
